// File: rtl/intc_pkg.sv
// ============================================================================
// Module      : intc_pkg
// Description : Shared types and widths for the prioritised interrupt
//               controller (state encoding, address and id widths).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package intc_pkg;

  localparam int INTC_AW  = 16;  // vector / return address width
  localparam int INTC_IDW = 4;   // interrupt id width (up to 16 lines)

  typedef enum logic [1:0] {
    INTC_IDLE    = 2'd0,
    INTC_REQ     = 2'd1,
    INTC_SERVICE = 2'd2
  } intc_state_e;

endpackage

`default_nettype wire

// File: rtl/intc_priority_encoder.sv
// ============================================================================
// Module      : intc_priority_encoder
// Description : Combinational lowest-index-first priority encoder. Bit 0 of
//               req has the highest priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intc_priority_encoder
  import intc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]          req,
  output logic                  valid,
  output logic [INTC_IDW-1:0]   id
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = INTC_IDW'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
// Module      : interrupt_controller
// Description : Prioritised interrupt controller. Latches rising edges on N
//               request lines, applies mask and global enable, handshakes
//               with the control FSM, presents the vector address and
//               saves/restores the return PC.
//               Optional feature macro: INTC_NESTING_EN (nested interrupts
//               with a DEPTH-entry return stack).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_controller
  import intc_pkg::*;
#(
  parameter int          N          = 8,
  parameter logic [15:0] VEC_BASE   = 16'hFF00,
  parameter int          VEC_STRIDE = 2,
  parameter int          DEPTH      = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N-1:0]        irq_in,
  input  logic                mask_we,
  input  logic [N-1:0]        mask_wdata,
  input  logic                ei,
  input  logic                di,
  input  logic                irq_ack,
  input  logic                reti,
  input  logic [INTC_AW-1:0]  pc_ret,
  output logic                irq_req,
  output logic [INTC_AW-1:0]  interrupts_addr,
  output logic [INTC_IDW-1:0] irq_id,
  output logic [INTC_AW-1:0]  ret_addr,
  output logic [N-1:0]        pending,
  output logic                gie_o,
  output logic                busy
);

  // An out-of-range configuration never raises a request
  localparam bit c_cfg_ok = (N >= 1) && (N <= 16) && (DEPTH >= 1);

  logic [N-1:0]          irq_prev_q, pending_q, pending_d, mask_q, mask_d;
  logic [N-1:0]          w_rise, w_elig, w_clr;
  logic                  gie_q, gie_d, irq_req_q, irq_req_d;
  logic [INTC_IDW-1:0]   irq_id_q, irq_id_d, w_win_id;
  logic [INTC_AW-1:0]    ret_addr_q, ret_addr_d;
  logic                  w_win_valid, w_ack, w_reti, w_can_req;
  intc_state_e           state_q, state_d;

`ifdef INTC_NESTING_EN
  localparam int                c_spw      = $clog2(DEPTH + 1);
  localparam logic [INTC_IDW:0] c_lvl_none = {1'b1, {INTC_IDW{1'b0}}};
  logic [INTC_AW-1:0]  pc_stk_q  [DEPTH];
  logic [INTC_AW-1:0]  pc_stk_d  [DEPTH];
  logic [INTC_IDW:0]   lvl_stk_q [DEPTH];
  logic [INTC_IDW:0]   lvl_stk_d [DEPTH];
  logic [INTC_IDW:0]   level_q, level_d;
  logic [c_spw-1:0]    sp_q, sp_d;
  logic                w_nest_ok;
`else
  logic [INTC_AW-1:0]  epc_q, epc_d;
`endif

  assign w_rise    = irq_in & ~irq_prev_q;
  assign w_elig    = pending_q & mask_q;
  assign w_ack     = irq_ack & irq_req_q;
  assign w_reti    = reti && (state_q == INTC_SERVICE);
  assign w_can_req = gie_q && w_win_valid && c_cfg_ok;

  intc_priority_encoder #(.N(N)) u_prio (
    .req   (w_elig),
    .valid (w_win_valid),
    .id    (w_win_id)
  );

`ifdef INTC_NESTING_EN
  // Nested entry needs a strictly higher priority line and free stack space
  assign w_nest_ok = w_can_req && ({1'b0, w_win_id} < level_q) &&
                     (sp_q != c_spw'(DEPTH));
`endif

  // One-hot clear of the presented line's pending bit on acknowledge
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N; i++) begin
      if (w_ack && (irq_id_q == INTC_IDW'(i))) w_clr[i] = 1'b1;
    end
  end

  // Next-state for pending, mask, enable and the request handshake FSM
  always_comb begin
    pending_d  = (pending_q & ~w_clr) | w_rise;  // a same-cycle rise wins
    mask_d     = mask_we ? mask_wdata : mask_q;
    state_d    = state_q;
    irq_req_d  = irq_req_q;
    irq_id_d   = irq_id_q;
    ret_addr_d = ret_addr_q;
    if (w_ack)                gie_d = 1'b0;
    else if (di)              gie_d = 1'b0;
    else if (ei || w_reti)    gie_d = 1'b1;
    else                      gie_d = gie_q;
`ifdef INTC_NESTING_EN
    pc_stk_d  = pc_stk_q;
    lvl_stk_d = lvl_stk_q;
    level_d   = level_q;
    sp_d      = sp_q;
    if (w_ack) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sp_q == c_spw'(i)) begin
          pc_stk_d[i]  = pc_ret;
          lvl_stk_d[i] = level_q;
        end
      end
      sp_d    = sp_q + c_spw'(1);
      level_d = {1'b0, irq_id_q};
    end
`else
    epc_d = epc_q;
`endif
    case (state_q)
      INTC_IDLE: begin
        if (w_can_req) begin
          irq_req_d = 1'b1;
          irq_id_d  = w_win_id;
          state_d   = INTC_REQ;
        end
      end
      INTC_REQ: begin
        if (w_ack) begin
`ifndef INTC_NESTING_EN
          epc_d     = pc_ret;
`endif
          irq_req_d = 1'b0;
          state_d   = INTC_SERVICE;
        end else if (!w_can_req) begin
          irq_req_d = 1'b0;           // withdrawal
          state_d   = INTC_IDLE;
        end else begin
          irq_id_d  = w_win_id;
        end
      end
      INTC_SERVICE: begin
`ifdef INTC_NESTING_EN
        if (reti) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (sp_q == c_spw'(i + 1)) begin
              ret_addr_d = pc_stk_q[i];
              level_d    = lvl_stk_q[i];
            end
          end
          sp_d      = sp_q - c_spw'(1);
          irq_req_d = 1'b0;
          if (sp_q == c_spw'(1)) state_d = INTC_IDLE;
        end else if (w_ack) begin
          irq_req_d = 1'b0;
        end else if (w_nest_ok) begin
          irq_req_d = 1'b1;
          irq_id_d  = w_win_id;
        end else begin
          irq_req_d = 1'b0;
        end
`else
        if (reti) begin
          ret_addr_d = epc_q;
          state_d    = INTC_IDLE;
        end
`endif
      end
      default: state_d = INTC_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      gie_q      <= 1'b0;
      irq_req_q  <= 1'b0;
      irq_id_q   <= '0;
      ret_addr_q <= '0;
      state_q    <= INTC_IDLE;
`ifdef INTC_NESTING_EN
      for (int i = 0; i < DEPTH; i++) begin
        pc_stk_q[i]  <= '0;
        lvl_stk_q[i] <= '0;
      end
      level_q <= c_lvl_none;
      sp_q    <= '0;
`else
      epc_q   <= '0;
`endif
    end else begin
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      gie_q      <= gie_d;
      irq_req_q  <= irq_req_d;
      irq_id_q   <= irq_id_d;
      ret_addr_q <= ret_addr_d;
      state_q    <= state_d;
`ifdef INTC_NESTING_EN
      pc_stk_q  <= pc_stk_d;
      lvl_stk_q <= lvl_stk_d;
      level_q   <= level_d;
      sp_q      <= sp_d;
`else
      epc_q     <= epc_d;
`endif
    end
  end

  assign irq_req         = irq_req_q;
  assign irq_id          = irq_id_q;
  assign interrupts_addr = VEC_BASE + INTC_AW'(irq_id_q) * INTC_AW'(VEC_STRIDE);
  assign ret_addr        = ret_addr_q;
  assign pending         = pending_q;
  assign gie_o           = gie_q;
  assign busy            = (state_q == INTC_SERVICE);

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Directed self-checking bench for interrupt_controller.
//               Honours INTC_NESTING_EN for the nested-entry scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  irq_in, mask_wdata, pending;
  logic        mask_we, ei, di, irq_ack, reti;
  logic [15:0] pc_ret, interrupts_addr, ret_addr;
  logic        irq_req, gie_o, busy;
  logic [3:0]  irq_id;

  int n_tests = 0;
  int n_fail  = 0;

  interrupt_controller dut (
    .clock           (clock),
    .reset           (reset),
    .irq_in          (irq_in),
    .mask_we         (mask_we),
    .mask_wdata      (mask_wdata),
    .ei              (ei),
    .di              (di),
    .irq_ack         (irq_ack),
    .reti            (reti),
    .pc_ret          (pc_ret),
    .irq_req         (irq_req),
    .interrupts_addr (interrupts_addr),
    .irq_id          (irq_id),
    .ret_addr        (ret_addr),
    .pending         (pending),
    .gie_o           (gie_o),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one edge and settle
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; irq_in = '0; mask_we = 0; mask_wdata = '0;
    ei = 0; di = 0; irq_ack = 0; reti = 0; pc_ret = '0;
    tick(); tick();
    check("rst_irq_req", irq_req, 0);
    check("rst_irq_id", irq_id, 0);
    check("rst_addr", interrupts_addr, 16'hFF00);
    check("rst_ret_addr", ret_addr, 0);
    check("rst_pending", pending, 0);
    check("rst_gie", gie_o, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    tick();

    // enable all lines and global enable
    mask_we = 1; mask_wdata = 8'hFF; ei = 1;
    tick();
    mask_we = 0; ei = 0;
    check("ei_gie", gie_o, 1);

    // single rise on line 3
    irq_in = 8'h08;
    tick();
    check("l3_pending", pending, 8'h08);
    check("l3_req_early", irq_req, 0);
    irq_in = 8'h00;
    tick();
    check("l3_req", irq_req, 1);
    check("l3_id", irq_id, 3);
    check("l3_addr", interrupts_addr, 16'hFF06);
    irq_ack = 1; pc_ret = 16'h0042;
    tick();
    irq_ack = 0;
    check("l3_busy", busy, 1);
    check("l3_gie_off", gie_o, 0);
    check("l3_pend_clr", pending, 0);
    check("l3_req_drop", irq_req, 0);
    reti = 1;
    tick();
    reti = 0;
    check("l3_ret", ret_addr, 16'h0042);
    check("l3_gie_on", gie_o, 1);
    check("l3_busy_off", busy, 0);

    // lines 5 and 1 together: 1 first, 5 after return
    irq_in = 8'h22;
    tick();
    irq_in = 8'h00;
    tick();
    check("p1_req", irq_req, 1);
    check("p1_id", irq_id, 1);
    check("p1_addr", interrupts_addr, 16'hFF02);
    irq_ack = 1; pc_ret = 16'h0010;
    tick();
    irq_ack = 0;
    check("p1_pending", pending, 8'h20);
    reti = 1;
    tick();
    reti = 0;
    tick();
    check("p5_req", irq_req, 1);
    check("p5_id", irq_id, 5);
    check("p5_addr", interrupts_addr, 16'hFF0A);
    irq_ack = 1; pc_ret = 16'h0020;
    tick();
    irq_ack = 0; reti = 1;
    tick();
    reti = 0;
    check("p5_ret", ret_addr, 16'h0020);

    // masked line 2 stays pending without request
    mask_we = 1; mask_wdata = 8'hFB;
    tick();
    mask_we = 0; irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    tick(); tick();
    check("m2_noreq", irq_req, 0);
    check("m2_pending", pending, 8'h04);
    mask_we = 1; mask_wdata = 8'hFF;
    tick();
    mask_we = 0;
    check("m2_req_wait", irq_req, 0);
    tick();
    check("m2_req", irq_req, 1);
    check("m2_id", irq_id, 2);

    // withdrawal by di
    di = 1;
    tick();
    di = 0;
    check("wd_gie", gie_o, 0);
    tick();
    check("wd_req", irq_req, 0);
    check("wd_pending", pending, 8'h04);
    check("wd_busy", busy, 0);
    ei = 1;
    tick();
    ei = 0;
    tick();
    check("wd_rereq", irq_req, 1);
    irq_ack = 1; pc_ret = 16'h0030;
    tick();
    irq_ack = 0; reti = 1;
    tick();
    reti = 0;
    check("wd_ret", ret_addr, 16'h0030);

    // ignored ack and reti in IDLE
    irq_ack = 1;
    tick();
    irq_ack = 0;
    check("ign_ack_busy", busy, 0);
    check("ign_ack_gie", gie_o, 1);
    reti = 1; pc_ret = 16'h7777;
    tick();
    reti = 0;
    check("ign_reti_ret", ret_addr, 16'h0030);
    ei = 1; di = 1;
    tick();
    ei = 0; di = 0;
    check("eidi_gie", gie_o, 0);
    ei = 1;
    tick();
    ei = 0;

    // service line 4, ISR enables, line 0 rises
    irq_in = 8'h10;
    tick();
    irq_in = 8'h00;
    tick();
    check("n4_id", irq_id, 4);
    irq_ack = 1; pc_ret = 16'h0200;
    tick();
    irq_ack = 0; ei = 1;
    tick();
    ei = 0;
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    tick();
`ifdef INTC_NESTING_EN
    check("n0_req", irq_req, 1);
    check("n0_id", irq_id, 0);
    irq_ack = 1; pc_ret = 16'h0100;
    tick();
    irq_ack = 0;
    check("n0_busy", busy, 1);
    check("n0_req_drop", irq_req, 0);
    reti = 1;
    tick();
    check("n0_ret1", ret_addr, 16'h0100);
    check("n0_busy1", busy, 1);
    tick();
    reti = 0;
    check("n0_ret2", ret_addr, 16'h0200);
    check("n0_busy2", busy, 0);
`else
    check("nn_noreq", irq_req, 0);
    tick();
    check("nn_noreq2", irq_req, 0);
    reti = 1;
    tick();
    reti = 0;
    check("nn_ret", ret_addr, 16'h0200);
    check("nn_busy", busy, 0);
    tick();
    check("nn_req", irq_req, 1);
    check("nn_id", irq_id, 0);
    irq_ack = 1; pc_ret = 16'h0300;
    tick();
    irq_ack = 0; reti = 1;
    tick();
    reti = 0;
    check("nn_ret2", ret_addr, 16'h0300);
`endif

    // reset discards pending and in-flight request
    irq_in = 8'h80;
    tick();
    irq_in = 8'h00;
    tick();
    check("r_req_pre", irq_req, 1);
    reset = 1'b0;
    tick();
    check("r_pending", pending, 0);
    check("r_req", irq_req, 0);
    check("r_gie", gie_o, 0);
    check("r_ret", ret_addr, 0);
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
